rop_dcr_ctrl: RTL and testbench



---
 rtl/rop_dcr_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_rop_dcr_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rop_dcr_ctrl.sv
// Double-buffered ROP state controller: DCR writes fill a shadow copy, COMMIT fences and drains
// the ROP pipeline before copying shadow to active. Optional stall counter under ROP_DCR_PERF_EN.
package rop_dcr_pkg;
  localparam int ROP_DEPTH_FUNC_BITS = 3;
  localparam int ROP_STENCIL_OP_BITS = 3;
  localparam int ROP_BLEND_MODE_BITS = 3;
  localparam int ROP_BLEND_FUNC_BITS = 4;
  localparam int ROP_LOGIC_OP_BITS   = 4;

  typedef struct packed {
    logic [ROP_STENCIL_OP_BITS-1:0] func;
    logic [ROP_STENCIL_OP_BITS-1:0] zpass;
    logic [ROP_STENCIL_OP_BITS-1:0] zfail;
    logic [ROP_STENCIL_OP_BITS-1:0] fail;
    logic [7:0]                     mask;
    logic [7:0]                     ref_val;
  } rop_stencil_t;

  typedef struct packed {
    logic [31:0]                    cbuf_addr;
    logic [31:0]                    cbuf_pitch;
    logic [31:0]                    cbuf_mask;
    logic [31:0]                    zbuf_addr;
    logic [31:0]                    zbuf_pitch;
    logic [ROP_DEPTH_FUNC_BITS-1:0] depth_func;
    logic                           depth_mask;
    rop_stencil_t                   stencil_front;
    rop_stencil_t                   stencil_back;
    logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_rgb;
    logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_a;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_rgb;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_a;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_rgb;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_a;
    logic [31:0]                    blend_const;
    logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
  } rop_dcrs_t;

  function automatic rop_dcrs_t rop_dcrs_reset_value();
    rop_dcrs_t v;
    v = {$bits(rop_dcrs_t){1'b0}};
    v.cbuf_mask          = 32'hFFFF_FFFF;
    v.depth_mask         = 1'b1;
    v.stencil_front.mask = 8'hFF;
    v.stencil_back.mask  = 8'hFF;
    return v;
  endfunction
endpackage

module rop_dcr_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic rop_rsp_fire,
  input logic count_zero
);
  // A retire with nothing outstanding means the front end lost track of its requests.
  assert property (@(posedge clk) disable iff (reset) !(rop_rsp_fire && count_zero));
endmodule

module rop_dcr_ctrl
  import rop_dcr_pkg::*;
#(
  parameter logic [11:0] DCR_BASE     = 12'h010,
  parameter int          MAX_INFLIGHT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcr_wr_valid,
  input  logic [11:0] dcr_wr_addr,
  input  logic [31:0] dcr_wr_data,
  output logic        dcr_wr_ready,
  input  logic        rop_req_fire,
  input  logic        rop_rsp_fire,
  output logic        rop_req_enable,
  output rop_dcrs_t   dcrs,
  output logic        dcrs_updated,
  output logic        busy,
  output logic [31:0] perf_stall_cycles
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  rop_dcrs_t        shadow_r, shadow_nxt_s;
  rop_dcrs_t        active_r;
  logic             updated_r;
  logic [11:0]      offset_s;
  logic             wr_accept_s;
  logic             commit_s;

  // Addresses below the base wrap to large offsets and fall outside the register map.
  assign offset_s    = dcr_wr_addr - DCR_BASE;
  assign wr_accept_s = dcr_wr_valid && (state_r == ST_IDLE);
  assign commit_s    = wr_accept_s && (offset_s == 12'd17);

  // In-flight count: simultaneous issue and retire cancel; an underflowing retire holds at zero.
  always_comb begin
    count_nxt_s = count_r;
    if (rop_req_fire && !rop_rsp_fire) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!rop_req_fire && rop_rsp_fire) begin
      if (count_r != CNT_ZERO) begin
        count_nxt_s = count_r - CNT_ONE;
      end else begin
        count_nxt_s = CNT_ZERO;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Commit sequencing; drain ends as soon as the count is about to reach zero.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) state_nxt_s = ST_DRAIN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (count_nxt_s == CNT_ZERO) state_nxt_s = ST_APPLY;
        else                         state_nxt_s = ST_DRAIN;
      end
      ST_APPLY: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Shadow register decode; fields narrower than their data lane are truncated.
  always_comb begin
    shadow_nxt_s = shadow_r;
    if (wr_accept_s) begin
      case (offset_s)
        12'd0:  shadow_nxt_s.cbuf_addr  = dcr_wr_data;
        12'd1:  shadow_nxt_s.cbuf_pitch = dcr_wr_data;
        12'd2:  shadow_nxt_s.cbuf_mask  = dcr_wr_data;
        12'd3:  shadow_nxt_s.zbuf_addr  = dcr_wr_data;
        12'd4:  shadow_nxt_s.zbuf_pitch = dcr_wr_data;
        12'd5:  shadow_nxt_s.depth_func = dcr_wr_data[ROP_DEPTH_FUNC_BITS-1:0];
        12'd6:  shadow_nxt_s.depth_mask = dcr_wr_data[0];
        12'd7: begin
          shadow_nxt_s.stencil_front.func = dcr_wr_data[0 +: ROP_STENCIL_OP_BITS];
          shadow_nxt_s.stencil_back.func  = dcr_wr_data[16 +: ROP_STENCIL_OP_BITS];
        end
        12'd8: begin
          shadow_nxt_s.stencil_front.zpass = dcr_wr_data[0 +: ROP_STENCIL_OP_BITS];
          shadow_nxt_s.stencil_back.zpass  = dcr_wr_data[16 +: ROP_STENCIL_OP_BITS];
        end
        12'd9: begin
          shadow_nxt_s.stencil_front.zfail = dcr_wr_data[0 +: ROP_STENCIL_OP_BITS];
          shadow_nxt_s.stencil_back.zfail  = dcr_wr_data[16 +: ROP_STENCIL_OP_BITS];
        end
        12'd10: begin
          shadow_nxt_s.stencil_front.fail = dcr_wr_data[0 +: ROP_STENCIL_OP_BITS];
          shadow_nxt_s.stencil_back.fail  = dcr_wr_data[16 +: ROP_STENCIL_OP_BITS];
        end
        12'd11: begin
          shadow_nxt_s.stencil_front.mask = dcr_wr_data[7:0];
          shadow_nxt_s.stencil_back.mask  = dcr_wr_data[23:16];
        end
        12'd12: begin
          shadow_nxt_s.stencil_front.ref_val = dcr_wr_data[7:0];
          shadow_nxt_s.stencil_back.ref_val  = dcr_wr_data[23:16];
        end
        12'd13: begin
          shadow_nxt_s.blend_mode_rgb = dcr_wr_data[0 +: ROP_BLEND_MODE_BITS];
          shadow_nxt_s.blend_mode_a   = dcr_wr_data[16 +: ROP_BLEND_MODE_BITS];
        end
        12'd14: begin
          shadow_nxt_s.blend_src_rgb = dcr_wr_data[0 +: ROP_BLEND_FUNC_BITS];
          shadow_nxt_s.blend_src_a   = dcr_wr_data[8 +: ROP_BLEND_FUNC_BITS];
          shadow_nxt_s.blend_dst_rgb = dcr_wr_data[16 +: ROP_BLEND_FUNC_BITS];
          shadow_nxt_s.blend_dst_a   = dcr_wr_data[24 +: ROP_BLEND_FUNC_BITS];
        end
        12'd15: shadow_nxt_s.blend_const = dcr_wr_data;
        12'd16: shadow_nxt_s.logic_op    = dcr_wr_data[ROP_LOGIC_OP_BITS-1:0];
        12'd17: shadow_nxt_s = shadow_r;
        default: shadow_nxt_s = shadow_r;
      endcase
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // State, count and both register copies; active only moves on the edge leaving APPLY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      shadow_r  <= rop_dcrs_reset_value();
      active_r  <= rop_dcrs_reset_value();
      updated_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      shadow_r  <= shadow_nxt_s;
      if (state_r == ST_APPLY) active_r <= shadow_r;
      else                     active_r <= active_r;
      updated_r <= (state_r == ST_APPLY);
    end
  end

`ifdef ROP_DCR_PERF_EN
  logic [31:0] perf_r;

  // Fenced-cycle counter, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset)                   perf_r <= 32'h0;
    else if (state_r != ST_IDLE) perf_r <= perf_r + 32'd1;
    else                         perf_r <= perf_r;
  end

  assign perf_stall_cycles = perf_r;
`else
  assign perf_stall_cycles = 32'h0;
`endif

  assign dcr_wr_ready   = (state_r == ST_IDLE);
  assign rop_req_enable = (state_r == ST_IDLE) && (count_r < CNT_MAX);
  assign busy           = (state_r != ST_IDLE);
  assign dcrs           = active_r;
  assign dcrs_updated   = updated_r;

  rop_dcr_ctrl_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .rop_rsp_fire (rop_rsp_fire),
    .count_zero   (count_r == CNT_ZERO)
  );
endmodule

// File: tb/tb_rop_dcr_ctrl.sv
// Bench for rop_dcr_ctrl: a word-level register-file model checked every cycle, plus
// directed commit scenarios with literal expectations.
module tb_rop_dcr_ctrl;
  import rop_dcr_pkg::*;

  localparam logic [11:0] BASE = 12'h010;
`ifdef ROP_DCR_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic        dcr_wr_ready;
  logic        rop_req_fire;
  logic        rop_rsp_fire;
  logic        rop_req_enable;
  rop_dcrs_t   dcrs;
  logic        dcrs_updated;
  logic        busy;
  logic [31:0] perf_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  rop_dcr_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .dcr_wr_valid      (dcr_wr_valid),
    .dcr_wr_addr       (dcr_wr_addr),
    .dcr_wr_data       (dcr_wr_data),
    .dcr_wr_ready      (dcr_wr_ready),
    .rop_req_fire      (rop_req_fire),
    .rop_rsp_fire      (rop_rsp_fire),
    .rop_req_enable    (rop_req_enable),
    .dcrs              (dcrs),
    .dcrs_updated      (dcrs_updated),
    .busy              (busy),
    .perf_stall_cycles (perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: registers held as raw 32-bit words, a commit flag, and an apply flag.
  logic [16:0][31:0] m_shadow, m_active;
  int          m_count;
  bit          m_pending, m_applying, m_updated;
  logic [31:0] m_perf;

  function automatic logic [16:0][31:0] reset_words();
    logic [16:0][31:0] w;
    for (int i = 0; i < 17; i++) w[i] = 32'h0;
    w[2]  = 32'hFFFF_FFFF;
    w[6]  = 32'h0000_0001;
    w[11] = 32'h00FF_00FF;
    return w;
  endfunction

  function automatic rop_dcrs_t words_to_dcrs(input logic [16:0][31:0] w);
    rop_dcrs_t r;
    r.cbuf_addr  = w[0];
    r.cbuf_pitch = w[1];
    r.cbuf_mask  = w[2];
    r.zbuf_addr  = w[3];
    r.zbuf_pitch = w[4];
    r.depth_func = w[5][ROP_DEPTH_FUNC_BITS-1:0];
    r.depth_mask = w[6][0];
    r.stencil_front.func    = w[7][0 +: ROP_STENCIL_OP_BITS];
    r.stencil_back.func     = w[7][16 +: ROP_STENCIL_OP_BITS];
    r.stencil_front.zpass   = w[8][0 +: ROP_STENCIL_OP_BITS];
    r.stencil_back.zpass    = w[8][16 +: ROP_STENCIL_OP_BITS];
    r.stencil_front.zfail   = w[9][0 +: ROP_STENCIL_OP_BITS];
    r.stencil_back.zfail    = w[9][16 +: ROP_STENCIL_OP_BITS];
    r.stencil_front.fail    = w[10][0 +: ROP_STENCIL_OP_BITS];
    r.stencil_back.fail     = w[10][16 +: ROP_STENCIL_OP_BITS];
    r.stencil_front.mask    = w[11][7:0];
    r.stencil_back.mask     = w[11][23:16];
    r.stencil_front.ref_val = w[12][7:0];
    r.stencil_back.ref_val  = w[12][23:16];
    r.blend_mode_rgb = w[13][0 +: ROP_BLEND_MODE_BITS];
    r.blend_mode_a   = w[13][16 +: ROP_BLEND_MODE_BITS];
    r.blend_src_rgb  = w[14][0 +: ROP_BLEND_FUNC_BITS];
    r.blend_src_a    = w[14][8 +: ROP_BLEND_FUNC_BITS];
    r.blend_dst_rgb  = w[14][16 +: ROP_BLEND_FUNC_BITS];
    r.blend_dst_a    = w[14][24 +: ROP_BLEND_FUNC_BITS];
    r.blend_const    = w[15];
    r.logic_op       = w[16][ROP_LOGIC_OP_BITS-1:0];
    return r;
  endfunction

  function automatic int next_count(input int c, input bit rq, input bit rs);
    if (rq && rs) return c;
    if (rq)       return c + 1;
    if (rs)       return (c > 0) ? c - 1 : 0;
    return c;
  endfunction

  function automatic int offset_of(input logic [11:0] a);
    return int'(a) - int'(BASE);
  endfunction

  initial begin
    m_shadow = reset_words();
    m_active = reset_words();
  end

  always @(posedge clk) begin
    if (reset) begin
      m_shadow   <= reset_words();
      m_active   <= reset_words();
      m_count    <= 0;
      m_pending  <= 1'b0;
      m_applying <= 1'b0;
      m_updated  <= 1'b0;
      m_perf     <= 32'h0;
    end else begin
      m_updated <= m_applying;
      m_perf    <= m_pending ? m_perf + 32'd1 : m_perf;
      m_count   <= next_count(m_count, rop_req_fire, rop_rsp_fire);
      if (m_applying) begin
        m_active   <= m_shadow;
        m_pending  <= 1'b0;
        m_applying <= 1'b0;
      end else begin
        if (m_pending && next_count(m_count, rop_req_fire, rop_rsp_fire) == 0)
          m_applying <= 1'b1;
        if (!m_pending && dcr_wr_valid && offset_of(dcr_wr_addr) == 17)
          m_pending <= 1'b1;
      end
      if (!m_pending && dcr_wr_valid && offset_of(dcr_wr_addr) >= 0 && offset_of(dcr_wr_addr) <= 16)
        m_shadow[5'(offset_of(dcr_wr_addr))] <= dcr_wr_data;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("ready",   512'(dcr_wr_ready),   512'(!m_pending));
      check("busy",    512'(busy),           512'(m_pending));
      check("enable",  512'(rop_req_enable), 512'(!m_pending && m_count < 64));
      check("updated", 512'(dcrs_updated),   512'(m_updated));
      check("dcrs",    512'(dcrs),           512'(words_to_dcrs(m_active)));
      check("perf",    512'(perf_stall_cycles), 512'(PERF_ON ? m_perf : 32'h0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Holds the write until accepted; returns in the cycle after acceptance.
  task automatic dcr_write(input logic [11:0] a, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    tick();
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = dcr_wr_ready;
      tick();
    end
    dcr_wr_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL dcr_write_timeout: addr %h not accepted within 200 cycles", a);
    end
  endtask

  initial begin
    reset = 1'b1; dcr_wr_valid = 1'b0; dcr_wr_addr = 12'h0; dcr_wr_data = 32'h0;
    rop_req_fire = 1'b0; rop_rsp_fire = 1'b0;
    repeat (3) tick();
    checking = 1'b1;
    reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_cbuf_mask",  512'(dcrs.cbuf_mask), 512'(32'hFFFF_FFFF));
    check("rst_depth_mask", 512'(dcrs.depth_mask), 512'(1'b1));
    check("rst_st_masks",   512'({dcrs.stencil_front.mask, dcrs.stencil_back.mask}), 512'(16'hFFFF));
    check("rst_cbuf_addr",  512'(dcrs.cbuf_addr), 512'(32'h0));
    check("rst_enable",     512'({rop_req_enable, busy, dcr_wr_ready}), 512'(3'b101));

    // Shadow write without commit, then minimum-latency commit
    dcr_write(BASE + 12'd0, 32'h8000_0000);
    repeat (10) tick();
    @(negedge clk);
    check("no_commit_cbuf", 512'(dcrs.cbuf_addr), 512'(32'h0));
    dcr_write(BASE + 12'd17, 32'h0);
    @(negedge clk);
    check("fence_t1", 512'({rop_req_enable, dcrs_updated}), 512'(2'b00));
    tick(); @(negedge clk);
    check("upd_t2", 512'({dcrs_updated, dcrs.cbuf_addr}), 512'({1'b0, 32'h0}));
    tick(); @(negedge clk);
    check("upd_t3", 512'({dcrs_updated, dcrs.cbuf_addr}), 512'({1'b1, 32'h8000_0000}));
    tick(); @(negedge clk);
    check("upd_t4", 512'(dcrs_updated), 512'(1'b0));

    // Five outstanding, one retire every 4 cycles
    tick(); rop_req_fire = 1'b1; repeat (5) tick(); rop_req_fire = 1'b0;
    dcr_write(BASE + 12'd15, 32'h1122_3344);
    dcr_write(BASE + 12'd17, 32'h0);
    @(negedge clk);
    check("drain_fence", 512'({rop_req_enable, dcr_wr_ready}), 512'(2'b00));
    for (int k = 0; k < 5; k++) begin
      repeat (3) tick();
      rop_rsp_fire = 1'b1;
      tick();
      rop_rsp_fire = 1'b0;
    end
    @(negedge clk);
    check("bc_r1", 512'({busy, dcrs.blend_const}), 512'({1'b1, 32'h0}));
    tick(); @(negedge clk);
    check("bc_r2", 512'({dcrs_updated, dcrs.blend_const}), 512'({1'b1, 32'h1122_3344}));

    // Simultaneous issue and retire during drain
    tick(); rop_req_fire = 1'b1; repeat (2) tick(); rop_req_fire = 1'b0;
    dcr_write(BASE + 12'd16, 32'h0000_0005);
    dcr_write(BASE + 12'd17, 32'h0);
    rop_req_fire = 1'b1; rop_rsp_fire = 1'b1;
    repeat (5) tick();
    rop_req_fire = 1'b0; rop_rsp_fire = 1'b0;
    @(negedge clk);
    check("both_hold", 512'({busy, dcrs.logic_op}), 512'({1'b1, 4'h0}));
    tick(); rop_rsp_fire = 1'b1; repeat (2) tick(); rop_rsp_fire = 1'b0;
    @(negedge clk);
    check("lo_apply", 512'({busy, dcrs.logic_op}), 512'({1'b1, 4'h0}));
    tick(); @(negedge clk);
    check("lo_new", 512'({dcrs_updated, dcrs.logic_op}), 512'({1'b1, 4'h5}));

    // Stencil ref lanes, then out-of-range writes
    dcr_write(BASE + 12'd12, 32'h00AB_00CD);
    dcr_write(BASE + 12'd17, 32'h0);
    repeat (3) tick(); @(negedge clk);
    check("st_ref", 512'({dcrs.stencil_front.ref_val, dcrs.stencil_back.ref_val}), 512'(16'hCDAB));
    dcr_write(BASE + 12'd20, 32'hDEAD_BEEF);
    dcr_write(BASE - 12'd1, 32'hDEAD_BEEF);
    dcr_write(BASE + 12'd17, 32'h0);
    repeat (3) tick(); @(negedge clk);
    check("oor_ignored", 512'({dcrs.stencil_front.ref_val, dcrs.cbuf_addr, dcrs.blend_const}),
          512'({8'hCD, 32'h8000_0000, 32'h1122_3344}));

    // Outstanding-request ceiling
    tick(); rop_req_fire = 1'b1; repeat (64) tick(); rop_req_fire = 1'b0;
    @(negedge clk);
    check("max_fence", 512'({rop_req_enable, busy}), 512'(2'b00));
    tick(); rop_rsp_fire = 1'b1; tick(); rop_rsp_fire = 1'b0;
    @(negedge clk);
    check("max_release", 512'(rop_req_enable), 512'(1'b1));
    tick(); rop_rsp_fire = 1'b1; repeat (63) tick(); rop_rsp_fire = 1'b0;

    // Six-cycle drain for the stall counter
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check("rst2", 512'({perf_stall_cycles, dcrs.cbuf_addr}), 512'({32'h0, 32'h0}));
    tick(); rop_req_fire = 1'b1; tick(); rop_req_fire = 1'b0;
    dcr_write(BASE + 12'd17, 32'h0);
    repeat (5) tick();
    rop_rsp_fire = 1'b1; tick(); rop_rsp_fire = 1'b0;
    tick(); @(negedge clk);
    check("perf7", 512'({busy, perf_stall_cycles}), 512'({1'b0, (PERF_ON ? 32'd7 : 32'd0)}));

    // Reset in the middle of a drain
    tick(); rop_req_fire = 1'b1; repeat (3) tick(); rop_req_fire = 1'b0;
    dcr_write(BASE + 12'd3, 32'hCAFE_0000);
    dcr_write(BASE + 12'd17, 32'h0);
    repeat (2) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ctl", 512'({busy, rop_req_enable, dcr_wr_ready, dcrs_updated}), 512'(4'b0110));
    check("mid_rst_dcrs", 512'({dcrs.zbuf_addr, dcrs.cbuf_mask, perf_stall_cycles}),
          512'({32'h0, 32'hFFFF_FFFF, 32'h0}));
    repeat (4) tick();
    dcr_write(BASE + 12'd17, 32'h0);
    repeat (3) tick(); @(negedge clk);
    check("mid_rst_shadow", 512'(dcrs.zbuf_addr), 512'(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
